bf_coeff_loader: RTL and testbench

BF_COEFF_LOADER -- requirements
Module: bf_coeff_loader

---
 rtl/bf_coeff_loader_if.sv | 24 ++
 rtl/bf_coeff_loader.sv | 85 ++++++++
 tb/tb_bf_coeff_loader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bf_coeff_loader_if.sv
// Coefficient load stream: one signed word per transfer, load_last on the final word of a set.
// Handshake: a word moves when load_valid and load_ready are both high on a rising clk edge.
interface bf_coeff_loader_if #(
  parameter int coeff_width = 16
);
  logic                          load_valid;
  logic                          load_ready;
  logic signed [coeff_width-1:0] load_data;
  logic                          load_last;

  modport master (
    output load_valid,
    output load_data,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_last,
    output load_ready
  );
endinterface

// File: rtl/bf_coeff_loader.sv
// Double-buffered beamformer coefficient loader: a shadow bank fills from the load
// stream and is copied into the active bank on the frame epoch strobe.
module bf_coeff_loader #(
  parameter int NCH         = 4,
  parameter int coeff_width = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  bf_coeff_loader_if.slave           ld,
  input  logic                       epoch,
  input  logic                       flush,
  output logic [NCH*coeff_width-1:0] coeff,
  output logic                       pending,
  output logic                       err_len,
  output logic [7:0]                 swap_cnt,
  output logic                       state_dbg
);

  localparam int IW = $clog2(NCH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);
  localparam logic [coeff_width-1:0] UNITY = coeff_width'(1) << (coeff_width - 2);
  localparam logic [NCH*coeff_width-1:0] RESET_COEFF =
    {{((NCH - 1) * coeff_width){1'b0}}, UNITY};

  typedef enum logic {
    LOAD = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [coeff_width-1:0] shadow [NCH];
  logic                   transfer;

  assign ld.load_ready = (state == LOAD);
  assign pending       = (state == PEND);
  assign state_dbg     = state;
  assign transfer      = ld.load_valid & ld.load_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= LOAD;
      idx      <= '0;
      err_len  <= 1'b0;
      swap_cnt <= 8'd0;
      coeff    <= RESET_COEFF;
      for (int i = 0; i < NCH; i++) shadow[i] <= '0;
    end else begin
      err_len <= 1'b0;
      if (flush) begin
        // Rewinding idx is enough to discard the shadow set: a set only reaches
        // PEND after all NCH words have been rewritten.
        state <= LOAD;
        idx   <= '0;
      end else begin
        case (state)
          LOAD: begin
            if (transfer) begin
              shadow[idx] <= ld.load_data;
              if (idx == LAST_IDX && ld.load_last) begin
                state <= PEND;
                idx   <= '0;
              end else if (idx == LAST_IDX || ld.load_last) begin
                err_len <= 1'b1;
                idx     <= '0;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
          PEND: begin
            if (epoch) begin
              for (int i = 0; i < NCH; i++)
                coeff[i*coeff_width +: coeff_width] <= shadow[i];
              swap_cnt <= swap_cnt + 8'd1;
              state    <= LOAD;
            end
          end
          default: state <= LOAD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bf_coeff_loader.sv
// Bench for bf_coeff_loader: directed vector table, randomized traffic against a
// set-level reference model, swap counter wrap and reset-in-PEND.
module tb_bf_coeff_loader;
  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int CW  = NCH * W;
  localparam logic [CW-1:0] RESET_COEFF = 64'h0000_0000_0000_4000;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          resetn;
  logic          epoch;
  logic          flush;
  logic [CW-1:0] coeff;
  logic          pending;
  logic          err_len;
  logic [7:0]    swap_cnt;
  logic          state_dbg;

  always #5 clk = ~clk;

  bf_coeff_loader_if #(.coeff_width(W)) ld ();

  bf_coeff_loader #(.NCH(NCH), .coeff_width(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ld        (ld),
    .epoch     (epoch),
    .flush     (flush),
    .coeff     (coeff),
    .pending   (pending),
    .err_len   (err_len),
    .swap_cnt  (swap_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (set level) ----------------
  logic [W-1:0] m_words[$];   // words collected so far / complete set awaiting epoch
  bit           m_pend;
  logic [W-1:0] m_active [NCH];
  int           m_swaps;
  bit           m_err;

  task automatic model_reset();
    m_words.delete();
    m_pend  = 1'b0;
    m_err   = 1'b0;
    m_swaps = 0;
    for (int i = 0; i < NCH; i++) m_active[i] = '0;
    m_active[0] = 16'd16384;
  endtask

  task automatic model_step(input bit v, input logic [W-1:0] d, input bit l,
                            input bit e, input bit f);
    m_err = 1'b0;
    if (f) begin
      m_words.delete();
      m_pend = 1'b0;
    end else if (!m_pend) begin
      if (v) begin
        m_words.push_back(d);
        if (l && m_words.size() == NCH) begin
          m_pend = 1'b1;
        end else if (l || m_words.size() == NCH) begin
          m_err = 1'b1;
          m_words.delete();
        end
      end
    end else if (e) begin
      for (int i = 0; i < NCH; i++) m_active[i] = m_words[i];
      m_words.delete();
      m_swaps = (m_swaps + 1) % 256;
      m_pend  = 1'b0;
    end
  endtask

  function automatic logic [CW-1:0] model_coeff();
    logic [CW-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*W +: W] = m_active[i];
    return r;
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".coeff"},    coeff,                    model_coeff());
    check({tag, ".pending"},  CW'(pending),             CW'(m_pend));
    check({tag, ".ready"},    CW'(ld.load_ready),       CW'(!m_pend));
    check({tag, ".err_len"},  CW'(err_len),             CW'(m_err));
    check({tag, ".swap_cnt"}, CW'(swap_cnt),            CW'(m_swaps[7:0]));
    check({tag, ".state"},    CW'(state_dbg),           CW'(m_pend));
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag, input bit v, input logic [W-1:0] d,
                      input bit l, input bit e, input bit f);
    ld.load_valid = v;
    ld.load_data  = d;
    ld.load_last  = l;
    epoch         = e;
    flush         = f;
    model_step(v, d, l, e, f);
    @(posedge clk);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic load_set(input string tag, input logic [W-1:0] base);
    for (int i = 0; i < NCH; i++)
      step(tag, 1'b1, base + W'(i), (i == NCH - 1), 1'b0, 1'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit           v;
    logic [W-1:0] d;
    bit           l;
    bit           e;
    bit           f;
    bit           x_pend;
    bit           x_err;
    logic [7:0]   x_sw;
    logic [W-1:0] x_c0;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit v, logic [W-1:0] d, bit l, bit e, bit f,
                              bit xp, bit xe, logic [7:0] xs, logic [W-1:0] xc);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.e = e; r.f = f;
    r.x_pend = xp; r.x_err = xe; r.x_sw = xs; r.x_c0 = xc;
    return r;
  endfunction

  initial begin
    // Set 100,-200,300,-400, epoch three cycles after the last word
    tbl.push_back(mk(1, 16'd100,  0, 0, 0, 0, 0, 8'd0, 16'd16384));
    tbl.push_back(mk(1, 16'hFF38, 0, 0, 0, 0, 0, 8'd0, 16'd16384));
    tbl.push_back(mk(1, 16'd300,  0, 0, 0, 0, 0, 8'd0, 16'd16384));
    tbl.push_back(mk(1, 16'hFE70, 1, 0, 0, 1, 0, 8'd0, 16'd16384));
    tbl.push_back(mk(0, 16'd0,    0, 0, 0, 1, 0, 8'd0, 16'd16384));
    tbl.push_back(mk(0, 16'd0,    0, 0, 0, 1, 0, 8'd0, 16'd16384));
    tbl.push_back(mk(0, 16'd0,    0, 1, 0, 0, 0, 8'd1, 16'd100));
    // Short set (last on 3rd word), then a good set
    tbl.push_back(mk(1, 16'd1,    0, 0, 0, 0, 0, 8'd1, 16'd100));
    tbl.push_back(mk(1, 16'd2,    0, 0, 0, 0, 0, 8'd1, 16'd100));
    tbl.push_back(mk(1, 16'd3,    1, 0, 0, 0, 1, 8'd1, 16'd100));
    tbl.push_back(mk(0, 16'd0,    0, 0, 0, 0, 0, 8'd1, 16'd100));
    tbl.push_back(mk(1, 16'd5,    0, 0, 0, 0, 0, 8'd1, 16'd100));
    tbl.push_back(mk(1, 16'd6,    0, 0, 0, 0, 0, 8'd1, 16'd100));
    tbl.push_back(mk(1, 16'd7,    0, 0, 0, 0, 0, 8'd1, 16'd100));
    tbl.push_back(mk(1, 16'd8,    1, 0, 0, 1, 0, 8'd1, 16'd100));
    tbl.push_back(mk(0, 16'd0,    0, 1, 0, 0, 0, 8'd2, 16'd5));
    // Final word and epoch together: no swap until the next epoch
    tbl.push_back(mk(1, 16'd11,   0, 0, 0, 0, 0, 8'd2, 16'd5));
    tbl.push_back(mk(1, 16'd12,   0, 0, 0, 0, 0, 8'd2, 16'd5));
    tbl.push_back(mk(1, 16'd13,   0, 0, 0, 0, 0, 8'd2, 16'd5));
    tbl.push_back(mk(1, 16'd14,   1, 1, 0, 1, 0, 8'd2, 16'd5));
    tbl.push_back(mk(0, 16'd0,    0, 1, 0, 0, 0, 8'd3, 16'd11));
    // Complete set, then flush with epoch: nothing swaps
    tbl.push_back(mk(1, 16'd21,   0, 0, 0, 0, 0, 8'd3, 16'd11));
    tbl.push_back(mk(1, 16'd22,   0, 0, 0, 0, 0, 8'd3, 16'd11));
    tbl.push_back(mk(1, 16'd23,   0, 0, 0, 0, 0, 8'd3, 16'd11));
    tbl.push_back(mk(1, 16'd24,   1, 0, 0, 1, 0, 8'd3, 16'd11));
    tbl.push_back(mk(0, 16'd0,    0, 1, 1, 0, 0, 8'd3, 16'd11));
    // Flush with a simultaneous mid-set transfer restarts at word 0, no err_len
    tbl.push_back(mk(1, 16'd31,   0, 0, 0, 0, 0, 8'd3, 16'd11));
    tbl.push_back(mk(1, 16'd32,   0, 0, 1, 0, 0, 8'd3, 16'd11));
    tbl.push_back(mk(1, 16'd41,   0, 0, 0, 0, 0, 8'd3, 16'd11));
    tbl.push_back(mk(1, 16'd42,   0, 0, 0, 0, 0, 8'd3, 16'd11));
    tbl.push_back(mk(1, 16'd43,   0, 0, 0, 0, 0, 8'd3, 16'd11));
    tbl.push_back(mk(1, 16'd44,   1, 0, 0, 1, 0, 8'd3, 16'd11));
    tbl.push_back(mk(0, 16'd0,    0, 1, 0, 0, 0, 8'd4, 16'd41));
    // Fourth word without last: length error
    tbl.push_back(mk(1, 16'd51,   0, 0, 0, 0, 0, 8'd4, 16'd41));
    tbl.push_back(mk(1, 16'd52,   0, 0, 0, 0, 0, 8'd4, 16'd41));
    tbl.push_back(mk(1, 16'd53,   0, 0, 0, 0, 0, 8'd4, 16'd41));
    tbl.push_back(mk(1, 16'd54,   0, 0, 0, 0, 1, 8'd4, 16'd41));
    tbl.push_back(mk(0, 16'd0,    0, 1, 0, 0, 0, 8'd4, 16'd41));
  end

  // ---------------- test sequence ----------------
  initial begin
    resetn        = 1'b0;
    ld.load_valid = 1'b0;
    ld.load_data  = '0;
    ld.load_last  = 1'b0;
    epoch         = 1'b0;
    flush         = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst.coeff",    coeff,              RESET_COEFF);
    check("rst.pending",  CW'(pending),       '0);
    check("rst.swap_cnt", CW'(swap_cnt),      '0);
    check("rst.err_len",  CW'(err_len),       '0);
    resetn = 1'b1;
    @(negedge clk);
    check("rel.ready",    CW'(ld.load_ready), CW'(1));
    check("rel.coeff",    coeff,              RESET_COEFF);

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(tag, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].e, tbl[i].f);
      check({tag, ".x_pend"}, CW'(pending),     CW'(tbl[i].x_pend));
      check({tag, ".x_err"},  CW'(err_len),     CW'(tbl[i].x_err));
      check({tag, ".x_sw"},   CW'(swap_cnt),    CW'(tbl[i].x_sw));
      check({tag, ".x_c0"},   CW'(coeff[W-1:0]), CW'(tbl[i].x_c0));
    end

    // Randomized traffic; last is biased toward the fourth word so sets complete
    for (int n = 0; n < 3000; n++) begin
      bit v, l, e, f;
      v = ($urandom_range(0, 9) < 7);
      if (m_words.size() == NCH - 1) l = ($urandom_range(0, 9) < 8);
      else                           l = ($urandom_range(0, 24) == 0);
      e = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 39) == 0);
      step("rnd", v, W'($urandom_range(0, 65535)), l, e, f);
    end

    // Drive swaps until the counter wraps through 255 to 0
    if (m_pend) step("wrap.pre", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 256; k++) begin
      load_set("wrap.set", W'(k * 8));
      step("wrap.ep", 1'b0, '0, 1'b0, 1'b1, 1'b0);
      if (m_swaps == 0) break;
    end
    check("wrap.swap_cnt", CW'(swap_cnt), '0);

    // Reset while a complete set is pending: set abandoned, reset bank restored
    load_set("rstpend.set", 16'h1234);
    check("rstpend.pending", CW'(pending), CW'(1));
    resetn = 1'b0;
    #1;
    check("rstpend.coeff",    coeff,              RESET_COEFF);
    check("rstpend.pending",  CW'(pending),       '0);
    check("rstpend.swap_cnt", CW'(swap_cnt),      '0);
    check("rstpend.ready",    CW'(ld.load_ready), CW'(1));
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    step("rstpend.ep", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("rstpend.noswap", coeff, RESET_COEFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
